// File: rtl/data_memory.sv
// Word-organised data RAM for the single-cycle datapath: combinational read,
// rising-edge write, asynchronous active-low clear of the whole array.
module data_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] Addr,
    input  logic [DATA_WIDTH-1:0] Write,
    output logic [DATA_WIDTH-1:0] Read,
    input  logic                  WE
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [IDX_W-1:0]      index_s;
    logic                  in_range_s;
    logic [DATA_WIDTH-1:0] read_s;
    logic                  unused_s;

    // Byte-offset bits never select a lane; the containing aligned word is used
    assign index_s    = Addr[IDX_W+1:2];
    assign in_range_s = (Addr[ADDR_WIDTH-1:IDX_W+2] == '0);
    assign unused_s   = ^Addr[1:0];

    // Storage: asynchronous clear, writes only for in-range addresses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (WE && in_range_s) begin
            mem_r[index_s] <= Write;
        end else begin
            mem_r[index_s] <= mem_r[index_s];
        end
    end

    // Combinational load path; out-of-range or held-in-reset reads return zero
    always_comb begin
        read_s = '0;
        if (rst_n && in_range_s) begin
            read_s = mem_r[index_s];
        end else begin
            read_s = '0;
        end
    end

    assign Read = read_s;

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory with hand-computed expectations.
module tb_data_memory;

    logic        clk;
    logic        rst_n;
    logic [31:0] Addr;
    logic [31:0] Write;
    logic [31:0] Read;
    logic        WE;

    int checks_r;
    int errors_r;

    data_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .Addr  (Addr),
        .Write (Write),
        .Read  (Read),
        .WE    (WE)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r++;
        if (got !== exp) begin
            errors_r++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive a single write cycle: set up on the falling edge, commit on the rising edge
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic we);
        @(negedge clk);
        Addr  = a;
        Write = d;
        WE    = we;
        @(posedge clk);
        #1;
        WE = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        Addr = a;
        #1;
        check_eq(tag, Read, exp);
    endtask

    initial begin
        checks_r = 0;
        errors_r = 0;
        rst_n = 1'b0;
        Addr  = 32'h0;
        Write = 32'h0;
        WE    = 1'b0;

        // 1. reset for two cycles, then sweep the whole array
        repeat (2) @(posedge clk);
        #1;
        rd("rst_hold_read", 32'h0000_0010, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) begin
            rd("rst_sweep", 32'(i * 4), 32'h0);
        end

        // 2. basic write then read back, neighbour untouched
        do_write(32'h0000_0004, 32'h0000_000A, 1'b1);
        rd("wr_rd_04", 32'h0000_0004, 32'h0000_000A);
        rd("wr_rd_08", 32'h0000_0008, 32'h0);

        // 3. write enable gating
        do_write(32'h0000_0060, 32'h0000_0007, 1'b0);
        rd("we0_no_write", 32'h0000_0060, 32'h0);
        do_write(32'h0000_0060, 32'h0000_0007, 1'b1);
        rd("we1_write", 32'h0000_0060, 32'h0000_0007);
        do_write(32'h0000_0060, 32'h0000_0000, 1'b0);
        rd("we0_hold", 32'h0000_0060, 32'h0000_0007);

        // 4. misaligned address hits the containing word
        do_write(32'h0000_0001, 32'hDEAD_BEEF, 1'b1);
        rd("mis_00", 32'h0000_0000, 32'hDEAD_BEEF);
        rd("mis_02", 32'h0000_0002, 32'hDEAD_BEEF);
        rd("mis_03", 32'h0000_0003, 32'hDEAD_BEEF);
        rd("mis_04_kept", 32'h0000_0004, 32'h0000_000A);

        // 5. out-of-range write is dropped without aliasing
        do_write(32'h0000_0100, 32'h1234_5678, 1'b1);
        rd("oor_read", 32'h0000_0100, 32'h0);
        rd("oor_no_alias", 32'h0000_0000, 32'hDEAD_BEEF);
        rd("oor_high", 32'h8000_00FC, 32'h0);
        rd("top_word", 32'h0000_00FC, 32'h0);
        do_write(32'h0000_00FC, 32'hA5A5_5A5A, 1'b1);
        rd("top_word_wr", 32'h0000_00FF, 32'hA5A5_5A5A);

        // 6. fill low words, then reset between edges
        for (int i = 0; i < 5; i++) begin
            do_write(32'(i * 4), 32'h1000_0000 + 32'(i), 1'b1);
        end
        rd("fill_00", 32'h0000_0000, 32'h1000_0000);
        rd("fill_10", 32'h0000_0010, 32'h1000_0004);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rd("midrst_clear", 32'(i * 4), 32'h0);
        end
        rd("midrst_60", 32'h0000_0060, 32'h0);
        Addr  = 32'h0000_0008;
        Write = 32'hFFFF_FFFF;
        WE    = 1'b1;
        @(posedge clk);
        #1;
        WE = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd("rst_write_blocked", 32'h0000_0008, 32'h0);
        rd("rst_cleared_60", 32'h0000_0060, 32'h0);
        rd("rst_cleared_fc", 32'h0000_00FC, 32'h0);
        do_write(32'h0000_0008, 32'h0BAD_F00D, 1'b1);
        rd("post_rst_write", 32'h0000_0008, 32'h0BAD_F00D);

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule
